// File: rtl/s1b_8b_pkg.sv
// Shared constants and types for the serial-to-byte aligner family.
// Comma character and the number of consecutive commas needed to declare alignment.
package s1b_8b_pkg;

    localparam logic [7:0] COMMA     = 8'hBC;
    localparam logic [2:0] BC_NEEDED = 3'd4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    function automatic logic is_comma(input logic [7:0] b);
        return (b == COMMA);
    endfunction

endpackage

// File: rtl/s1b_8b.sv
// Serial (MSB first) to byte converter that aligns on 4 consecutive comma bytes.
// Latency: byte registered on the edge sampling its LSB, visible the following cycle.
// Backpressure: none; free-running stream, outputs held for one byte period (8 cycles).
module s1b_8b
    import s1b_8b_pkg::*;
(
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    state_t      state, state_nxt;
    logic [7:0]  sr;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [2:0]  bc_cnt, bc_cnt_nxt;
    logic [7:0]  data_nxt;
    logic        valid_nxt;
    logic        active_nxt;
    logic [7:0]  candidate;
    logic        boundary;
    logic        cand_comma;

    assign candidate  = {sr[6:0], data_in};
    assign boundary   = (bit_cnt == 3'd7);
    assign cand_comma = is_comma(candidate);

    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state     <= SEARCH;
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
            bc_cnt    <= 3'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= candidate;
            bit_cnt   <= bit_cnt_nxt;
            bc_cnt    <= bc_cnt_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            active    <= active_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = 3'(bit_cnt + 3'd1);
        bc_cnt_nxt  = bc_cnt;
        data_nxt    = data_out;
        valid_nxt   = valid_out;
        active_nxt  = active;

        unique case (state)
            SEARCH: begin
                // Unaligned: a comma can start on any bit, so the bit counter is parked.
                bit_cnt_nxt = 3'd0;
                data_nxt    = 8'h00;
                valid_nxt   = 1'b0;
                active_nxt  = 1'b0;
                if (cand_comma) begin
                    state_nxt  = COUNT;
                    bc_cnt_nxt = 3'd1;
                end
            end
            COUNT: begin
                data_nxt   = 8'h00;
                valid_nxt  = 1'b0;
                active_nxt = 1'b0;
                if (boundary) begin
                    if (cand_comma) begin
                        if (bc_cnt < BC_NEEDED)
                            bc_cnt_nxt = 3'(bc_cnt + 3'd1);
                        if (3'(bc_cnt + 3'd1) >= BC_NEEDED) begin
                            state_nxt  = ACTIVE;
                            active_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt  = SEARCH;
                        bc_cnt_nxt = 3'd0;
                    end
                end
            end
            ACTIVE: begin
                // Alignment is sticky; only reset leaves this state.
                active_nxt = 1'b1;
                if (boundary) begin
                    if (cand_comma) begin
                        valid_nxt = 1'b0;
                    end else begin
                        data_nxt  = candidate;
                        valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt   = SEARCH;
                bit_cnt_nxt = 3'd0;
                bc_cnt_nxt  = 3'd0;
                data_nxt    = 8'h00;
                valid_nxt   = 1'b0;
                active_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_s1b_8b.sv
// Directed byte-stream vectors for the comma aligner, checked at each byte boundary
// and for output stability inside every byte period.
module tb_s1b_8b;

    logic       clk_32f;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int tests_run = 0;
    int tests_failed = 0;

    s1b_8b dut (
        .clk_32f  (clk_32f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    // pre: 0 = none, 1 = full reset + 3 random bits, 2 = reset mid-byte
    typedef struct {
        int         pre;
        logic [7:0] b;
        logic       act;
        logic       vld;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl[24];

    logic       prev_act;
    logic       prev_vld;
    logic [7:0] prev_dat;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic a, input logic v, input logic [7:0] d);
        chk({tag, ".active"}, {7'd0, active}, {7'd0, a});
        chk({tag, ".valid_out"}, {7'd0, valid_out}, {7'd0, v});
        chk({tag, ".data_out"}, data_out, d);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_32f);
        reset_L = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
            if (i < cycles - 1) @(negedge clk_32f);
        end
        chk_outs("reset", 1'b0, 1'b0, 8'h00);
        @(negedge clk_32f);
        reset_L = 1'b1;
        prev_act = 1'b0;
        prev_vld = 1'b0;
        prev_dat = 8'h00;
    endtask

    // Outputs must stay at the previous byte's values for the first 7 bits,
    // then take the expected values on the edge sampling the LSB.
    task automatic send_byte(input int idx, input logic [7:0] b, input logic a,
                             input logic v, input logic [7:0] d);
        logic held;
        held = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk_32f);
            data_in = b[i];
            @(posedge clk_32f);
            #1;
            if (i > 0 && (active !== prev_act || valid_out !== prev_vld || data_out !== prev_dat))
                held = 1'b0;
        end
        tests_run++;
        if (!held) begin
            tests_failed++;
            $display("FAIL hold[%0d]: outputs changed mid-byte, expected act=%b vld=%b dat=%h",
                     idx, prev_act, prev_vld, prev_dat);
        end
        chk($sformatf("vec%0d.active", idx), {7'd0, active}, {7'd0, a});
        chk($sformatf("vec%0d.valid_out", idx), {7'd0, valid_out}, {7'd0, v});
        chk($sformatf("vec%0d.data_out", idx), data_out, d);
        prev_act = a;
        prev_vld = v;
        prev_dat = d;
    endtask

    initial begin
        reset_L = 1'b0;
        data_in = 1'b0;

        // Alignment after 3 random bits, payload with idles, straddling comma
        tbl[0]  = '{1, 8'hBC, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{0, 8'hBC, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{0, 8'hBC, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{0, 8'hBC, 1'b1, 1'b0, 8'h00};
        tbl[4]  = '{0, 8'hA5, 1'b1, 1'b1, 8'hA5};
        tbl[5]  = '{0, 8'h01, 1'b1, 1'b1, 8'h01};
        tbl[6]  = '{0, 8'hBC, 1'b1, 1'b0, 8'h01};
        tbl[7]  = '{0, 8'hFF, 1'b1, 1'b1, 8'hFF};
        tbl[8]  = '{0, 8'h0B, 1'b1, 1'b1, 8'h0B};
        tbl[9]  = '{0, 8'hC0, 1'b1, 1'b1, 8'hC0};
        // Broken comma count
        tbl[10] = '{1, 8'hBC, 1'b0, 1'b0, 8'h00};
        tbl[11] = '{0, 8'hBC, 1'b0, 1'b0, 8'h00};
        tbl[12] = '{0, 8'h11, 1'b0, 1'b0, 8'h00};
        tbl[13] = '{0, 8'hBC, 1'b0, 1'b0, 8'h00};
        tbl[14] = '{0, 8'hBC, 1'b0, 1'b0, 8'h00};
        tbl[15] = '{0, 8'hBC, 1'b0, 1'b0, 8'h00};
        tbl[16] = '{0, 8'hBC, 1'b1, 1'b0, 8'h00};
        tbl[17] = '{0, 8'h5A, 1'b1, 1'b1, 8'h5A};
        tbl[18] = '{0, 8'hBC, 1'b1, 1'b0, 8'h5A};
        // Reset mid-byte while active, then realignment
        tbl[19] = '{2, 8'hBC, 1'b0, 1'b0, 8'h00};
        tbl[20] = '{0, 8'hBC, 1'b0, 1'b0, 8'h00};
        tbl[21] = '{0, 8'hBC, 1'b0, 1'b0, 8'h00};
        tbl[22] = '{0, 8'hBC, 1'b1, 1'b0, 8'h00};
        tbl[23] = '{0, 8'h3C, 1'b1, 1'b1, 8'h3C};

        prev_act = 1'b0;
        prev_vld = 1'b0;
        prev_dat = 8'h00;

        for (int k = 0; k < 24; k++) begin
            if (tbl[k].pre == 1) begin
                do_reset(2);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk_32f);
                    data_in = 1'($urandom_range(0, 1));
                    @(posedge clk_32f);
                    #1;
                    chk_outs("pre_bits", 1'b0, 1'b0, 8'h00);
                end
            end else if (tbl[k].pre == 2) begin
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk_32f);
                    data_in = 1'($urandom_range(0, 1));
                end
                @(posedge clk_32f);
                #1;
                chk_outs("before_midreset", 1'b1, 1'b0, 8'h5A);
                do_reset(1);
            end
            send_byte(k, tbl[k].b, tbl[k].act, tbl[k].vld, tbl[k].dat);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
